// File: rtl/mixer_seq.sv
// mixer_seq: hardware power sequencer for the RF mixer analog controls (pd/ota/buff).
// Brings bias, OTA and buffers up in order with programmable settle delays and tears them down in reverse.
module mixer_seq #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int DLY_W      = 16,
    parameter int T_BIAS_RST = 100,
    parameter int T_OTA_RST  = 50,
    parameter int T_BUFF_RST = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              pd,
    output logic              ota,
    output logic [1:0]        buff,
    output logic              done
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_UP_BIAS = 3'd1,
        S_UP_OTA  = 3'd2,
        S_UP_BUFF = 3'd3,
        S_ON      = 3'd4,
        S_DN_BUFF = 3'd5,
        S_DN_OTA  = 3'd6
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DLY_W-1:0]   cnt;
    logic [DLY_W-1:0]   cnt_nxt;
    logic [DLY_W-1:0]   t_bias;
    logic [DLY_W-1:0]   t_ota;
    logic [DLY_W-1:0]   t_buff;
    logic [1:0]         buff_cfg;
    logic               done_nxt;
    logic               pd_nxt;
    logic               ota_nxt;
    logic [1:0]         buff_nxt;
    logic [DATA_W-1:0]  rd_val;
    logic               wr;
    logic               up_req;
    logic               dn_req;
    logic               expired;
    logic               unused_wdata;

    assign wr           = valid && wstrb;
    assign up_req       = wr && (address == ADDR_W'(0)) && wdata[0];
    assign dn_req       = wr && (address == ADDR_W'(0)) && !wdata[0];
    assign expired      = (cnt == '0);
    assign unused_wdata = ^wdata[DATA_W-1:DLY_W];

    // Sequencer: a CTRL request that is not ignored takes priority over counter expiry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            S_OFF: begin
                if (up_req) begin
                    state_nxt = S_UP_BIAS;
                    cnt_nxt   = t_bias;
                end
            end
            S_UP_BIAS: begin
                if (dn_req) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else if (expired) begin
                    state_nxt = S_UP_OTA;
                    cnt_nxt   = t_ota;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            S_UP_OTA: begin
                if (dn_req) begin
                    state_nxt = S_DN_OTA;
                    cnt_nxt   = t_ota;
                end else if (expired) begin
                    state_nxt = S_UP_BUFF;
                    cnt_nxt   = t_buff;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            S_UP_BUFF: begin
                if (dn_req) begin
                    state_nxt = S_DN_BUFF;
                    cnt_nxt   = t_buff;
                end else if (expired) begin
                    state_nxt = S_ON;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            S_ON: begin
                if (dn_req) begin
                    state_nxt = S_DN_BUFF;
                    cnt_nxt   = t_buff;
                end
            end
            S_DN_BUFF: begin
                if (expired) begin
                    state_nxt = S_DN_OTA;
                    cnt_nxt   = t_ota;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            S_DN_OTA: begin
                if (expired) begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - DLY_W'(1);
                end
            end
            default: begin
                state_nxt = S_OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Analog controls are decoded from the next state so they line up with the state register.
    always_comb begin
        pd_nxt   = (state_nxt == S_OFF);
        ota_nxt  = (state_nxt == S_UP_OTA) || (state_nxt == S_UP_BUFF) ||
                   (state_nxt == S_ON)     || (state_nxt == S_DN_BUFF);
        buff_nxt = ((state_nxt == S_UP_BUFF) || (state_nxt == S_ON)) ? buff_cfg : 2'b00;
    end

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_W'(1): rd_val[1:0]       = buff_cfg;
            ADDR_W'(2): rd_val[DLY_W-1:0] = t_bias;
            ADDR_W'(3): rd_val[DLY_W-1:0] = t_ota;
            ADDR_W'(4): rd_val[DLY_W-1:0] = t_buff;
            ADDR_W'(5): begin
                rd_val[2:0] = state;
                rd_val[3]   = (state != S_OFF) && (state != S_ON);
                rd_val[4]   = (state == S_ON);
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OFF;
            cnt   <= '0;
            pd    <= 1'b1;
            ota   <= 1'b0;
            buff  <= 2'b00;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pd    <= pd_nxt;
            ota   <= ota_nxt;
            buff  <= buff_nxt;
            done  <= done_nxt;
        end
    end

    // Register writes land after the sequencer has already loaded from the old values.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_bias   <= DLY_W'(T_BIAS_RST);
            t_ota    <= DLY_W'(T_OTA_RST);
            t_buff   <= DLY_W'(T_BUFF_RST);
            buff_cfg <= 2'b01;
        end else if (wr) begin
            case (address)
                ADDR_W'(1): buff_cfg <= wdata[1:0];
                ADDR_W'(2): t_bias   <= wdata[DLY_W-1:0];
                ADDR_W'(3): t_ota    <= wdata[DLY_W-1:0];
                ADDR_W'(4): t_buff   <= wdata[DLY_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= valid;
            rdata <= (valid && !wstrb) ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_mixer_seq.sv
// tb_mixer_seq: directed test-plan checks plus randomized CPU traffic against a table-driven sequencer model.
module tb_mixer_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic        wstrb = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        pd;
    logic        ota;
    logic [1:0]  buff;
    logic        done;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    mixer_seq dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .pd(pd), .ota(ota),
        .buff(buff), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: phase number plus cycles left in the current dwell.
    int          m_phase;
    int          m_rem;
    int          m_tb, m_to, m_tf;
    int          m_cfg;
    int          e_ready, e_rdata, e_pd, e_ota, e_buff, e_done;
    int          fwd_tab   [7] = '{0, 2, 3, 4, 4, 6, 0};
    int          abort_tab [7] = '{0, 0, 6, 5, 5, 5, 6};

    function automatic int dwell_of(input int p);
        case (p)
            1:       return m_tb;
            2, 6:    return m_to;
            3, 5:    return m_tf;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int  nxt;
        bit  up, dn;
        if (rst) begin
            m_phase = 0; m_rem = 0;
            m_tb = 100; m_to = 50; m_tf = 20; m_cfg = 1;
            e_ready = 0; e_rdata = 0; e_pd = 1; e_ota = 0; e_buff = 0; e_done = 0;
        end else begin
            e_ready = valid;
            e_rdata = 0;
            if (valid && !wstrb) begin
                case (address)
                    3'd1: e_rdata = m_cfg;
                    3'd2: e_rdata = m_tb;
                    3'd3: e_rdata = m_to;
                    3'd4: e_rdata = m_tf;
                    3'd5: e_rdata = m_phase + ((m_phase != 0 && m_phase != 4) ? 8 : 0) + ((m_phase == 4) ? 16 : 0);
                    default: e_rdata = 0;
                endcase
            end
            up = valid && wstrb && address == 3'd0 && wdata[0];
            dn = valid && wstrb && address == 3'd0 && !wdata[0];
            nxt = m_phase;
            e_done = 0;
            if (up && m_phase == 0) nxt = 1;
            else if (dn && m_phase >= 1 && m_phase <= 4) nxt = abort_tab[m_phase];
            else if (m_phase != 0 && m_phase != 4) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) nxt = fwd_tab[m_phase];
            end
            if (nxt != m_phase) begin
                if (nxt == 0 || (nxt == 4 && m_phase == 3)) e_done = 1;
                m_phase = nxt;
                m_rem = dwell_of(nxt) + 1;
            end
            e_pd   = (m_phase == 0);
            e_ota  = (m_phase >= 2 && m_phase <= 5);
            e_buff = (m_phase == 3 || m_phase == 4) ? m_cfg : 0;
            if (valid && wstrb) begin
                case (address)
                    3'd1: m_cfg = int'(wdata[1:0]);
                    3'd2: m_tb  = int'(wdata[15:0]);
                    3'd3: m_to  = int'(wdata[15:0]);
                    3'd4: m_tf  = int'(wdata[15:0]);
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("ready", int'(ready), e_ready);
            chk("rdata", int'(rdata), e_rdata);
            chk("pd",    int'(pd),    e_pd);
            chk("ota",   int'(ota),   e_ota);
            chk("buff",  int'(buff),  e_buff);
            chk("done",  int'(done),  e_done);
        end
    end

    task automatic bus(input logic [2:0] a, input logic w, input logic [31:0] d);
        valid = 1'b1; address = a; wstrb = w; wdata = d;
        @(negedge clk);
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output int v);
        bus(a, 1'b0, 32'd0);
        v = int'(rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int v;
        idle(2);
        rst = 1'b0;
        check_en = 1'b1;
        chk("rst_pd", int'(pd), 1);
        chk("rst_ota", int'(ota), 0);
        chk("rst_buff", int'(buff), 0);
        chk("rst_ready", int'(ready), 0);
        rd(3'd5, v); chk("rst_status", v, 32'h00);
        rd(3'd2, v); chk("rst_t_bias", v, 100);
        rd(3'd1, v); chk("rst_buff_cfg", v, 1);

        // Full power-up with short delays.
        bus(3'd2, 1'b1, 32'd2);
        bus(3'd3, 1'b1, 32'd1);
        bus(3'd4, 1'b1, 32'd0);
        bus(3'd1, 1'b1, 32'd3);
        bus(3'd0, 1'b1, 32'd1);
        chk("up_pd_fall", int'(pd), 0);
        chk("up_ota_low", int'(ota), 0);
        idle(3);
        chk("up_ota_rise", int'(ota), 1);
        chk("up_buff_wait", int'(buff), 0);
        idle(2);
        chk("up_buff_on", int'(buff), 3);
        chk("up_done_early", int'(done), 0);
        idle(1);
        chk("up_done", int'(done), 1);
        idle(1);
        chk("up_done_once", int'(done), 0);
        rd(3'd5, v); chk("on_status", v, 32'h14);

        // BUFF_CFG change while ON reaches buff one edge after the write.
        bus(3'd1, 1'b1, 32'd2);
        chk("cfg_buff_old", int'(buff), 3);
        idle(1);
        chk("cfg_buff_new", int'(buff), 2);
        bus(3'd1, 1'b1, 32'd3);
        idle(1);

        // Power-down.
        bus(3'd0, 1'b1, 32'd0);
        chk("dn_buff_off", int'(buff), 0);
        chk("dn_ota_hold", int'(ota), 1);
        idle(1);
        chk("dn_ota_off", int'(ota), 0);
        chk("dn_pd_hold", int'(pd), 0);
        idle(2);
        chk("dn_pd_rise", int'(pd), 1);
        chk("dn_done", int'(done), 1);
        rd(3'd5, v); chk("off_status", v, 32'h00);

        // Abort during bias settle.
        bus(3'd2, 1'b1, 32'd10);
        bus(3'd0, 1'b1, 32'd1);
        idle(1);
        chk("abort_ota", int'(ota), 0);
        bus(3'd0, 1'b1, 32'd0);
        chk("abort_pd", int'(pd), 1);
        chk("abort_done", int'(done), 1);
        idle(1);
        chk("abort_done_once", int'(done), 0);

        // Ignored requests in ON and DN_OTA.
        bus(3'd2, 1'b1, 32'd0);
        bus(3'd3, 1'b1, 32'd3);
        bus(3'd0, 1'b1, 32'd1);
        idle(8);
        rd(3'd5, v); chk("ign_on_status", v, 32'h14);
        bus(3'd0, 1'b1, 32'd1);
        chk("ign_on_ready", int'(ready), 1);
        chk("ign_on_ota", int'(ota), 1);
        chk("ign_on_buff", int'(buff), 3);
        rd(3'd5, v); chk("ign_on_status2", v, 32'h14);
        bus(3'd0, 1'b1, 32'd0);
        idle(1);
        bus(3'd0, 1'b1, 32'd0);
        chk("ign_dn_ready", int'(ready), 1);
        chk("ign_dn_pd", int'(pd), 0);
        chk("ign_dn_ota", int'(ota), 0);
        rd(3'd5, v); chk("ign_dn_status", v, 32'h0E);
        idle(4);

        // Reset during UP_OTA.
        bus(3'd3, 1'b1, 32'd5);
        bus(3'd0, 1'b1, 32'd1);
        idle(1);
        chk("pre_rst_ota", int'(ota), 1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_pd", int'(pd), 1);
        chk("mid_rst_ota", int'(ota), 0);
        chk("mid_rst_buff", int'(buff), 0);
        rd(3'd5, v); chk("mid_rst_status", v, 0);
        rd(3'd3, v); chk("mid_rst_t_ota", v, 50);

        // Randomized traffic with small delays and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 699) == 0);
            valid   = ($urandom_range(0, 2) != 0);
            address = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            wstrb   = ($urandom_range(0, 1) == 1);
            wdata   = 32'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) wdata = wdata | ($urandom() & 32'hFFFF_0000);
            @(negedge clk);
        end
        rst = 1'b0;
        valid = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
